weight_bank_scheduler: RTL
==========================

WEIGHT_BANK_SCHEDULER -- requirements
Module: weight_bank_scheduler

Interface
REQ-001 Parameter ADDR_W, default 16: weight-memory word address width; the MSB selects bank 0 or bank 1.
REQ-002 Parameter LEN_W, default 15: width of the load length field.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 load_req  in  1  level request to fill the next bank.
REQ-006 load_len  in  LEN_W  number of words to load; sampled at acceptance.
REQ-007 load_is_cnn  in  1  1 = CNN weight layout, 0 = FC layout; sampled at acceptance.
REQ-008 load_ack  out  1  one-cycle pulse when a load is accepted.
REQ-009 in_valid  in  1  write beat valid from the DMA/stream source.
REQ-010 in_ready  out  1  the block can accept a write beat.
REQ-011 wr_en_fc  out  1  FC write enable to weight memory.
REQ-012 wr_en_cnn  out  1  CNN write enable to weight memory.
REQ-013 wr_addr  out  ADDR_W  write address, formed as {fill bank, offset}.
REQ-014 load_done  out  1  one-cycle pulse after the final beat of a load.
REQ-015 cmp_req  in  1  level request from the compute sequencer for a full bank.
REQ-016 cmp_grant  out  1  one-cycle pulse when a bank is granted to compute.
REQ-017 cmp_bank  out  1  bank owned by compute; drives the MSB of the read pointer.
REQ-018 cmp_active  out  1  compute currently owns cmp_bank.
REQ-019 cmp_release  in  1  compute has finished with cmp_bank.
REQ-020 bank_full  out  2  per-bank FULL status flag.

Function
REQ-021 Each bank SHALL be in one of three states: EMPTY, FULL or IN_USE.
REQ-022 Registers fill_ptr and rd_ptr (1 bit each) SHALL select the next bank to fill and the next bank to read.
REQ-023 The loader FSM SHALL have two states, IDLE and LOAD.
REQ-024 IDLE -> LOAD on load_req when bank[fill_ptr] is EMPTY.
- load_ack pulses in the first LOAD cycle.
- len, mode and offset counter = 0 are captured on the transition.
REQ-025 load_req SHALL be ignored, with no ack, while in LOAD or while bank[fill_ptr] is not EMPTY.
REQ-026 In LOAD, in_ready = 1; in_ready = 0 in IDLE.
REQ-027 Write enables and address SHALL be combinational, with zero latency:
- beat = in_valid & in_ready;
- wr_en_cnn = beat & mode, wr_en_fc = beat & ~mode;
- wr_addr = {fill_ptr, offset[ADDR_W-2:0]}.
REQ-028 The offset SHALL increment by 1 per beat and wrap modulo 2^(ADDR_W-1).
REQ-029 On the beat where offset == len-1, the following SHALL all happen on the next edge:
- return to IDLE;
- bank[fill_ptr] becomes FULL;
- fill_ptr toggles;
- load_done pulses for one cycle.
REQ-030 If load_len == 0, the load SHALL be accepted:
- load_ack pulses, no beats are accepted, and in_ready stays 0;
- the bank becomes FULL, fill_ptr toggles and load_done pulses one cycle after load_ack.
REQ-031 Grant: when cmp_req = 1, cmp_active = 0 and bank[rd_ptr] is FULL, on the next edge:
- bank[rd_ptr] becomes IN_USE;
- cmp_bank = rd_ptr and cmp_active = 1;
- cmp_grant pulses for one cycle.
REQ-032 Release: cmp_release while cmp_active = 1 SHALL, on the next edge:
- set bank[cmp_bank] to EMPTY;
- toggle rd_ptr;
- clear cmp_active.
cmp_release while cmp_active = 0 SHALL be ignored.
REQ-033 cmp_req and cmp_release in the same cycle: release SHALL be processed and the grant evaluated in the following cycle at the earliest.
REQ-034 Load completion and release in the same cycle SHALL both take effect; they necessarily act on different banks.
REQ-035 A release that empties bank[fill_ptr] SHALL allow a pending load_req to be accepted on the next cycle.
REQ-036 cmp_bank SHALL hold its value after release until the next grant.
REQ-037 bank_full[b] = 1 if and only if bank b is FULL.

Reset
REQ-038 On reset assertion, the block SHALL asynchronously:
- set both banks to EMPTY;
- clear fill_ptr, rd_ptr and cmp_bank to 0;
- set the FSM to IDLE;
- drive load_ack, load_done, cmp_grant, cmp_active, in_ready, wr_en_fc and wr_en_cnn to 0, wr_addr to 0 and bank_full to 2'b00.
REQ-039 Reset asserted mid-load SHALL abort the load with no load_done and leave the bank EMPTY.

Verification
REQ-040 FC load of length 4 into bank 0, in_valid held high:
- wr_en_fc is high for 4 cycles with wr_addr 0x0000..0x0003;
- load_done pulses once;
- bank_full = 2'b01.
REQ-041 Second load of length 2 with load_is_cnn = 1:
- wr_en_cnn is high with wr_addr 0x8000 and 0x8001;
- bank_full = 2'b11;
- a third load_req receives no load_ack.
REQ-042 cmp_req with bank 0 FULL:
- cmp_grant pulses one cycle later with cmp_bank = 0;
- after cmp_release, bank 0 is EMPTY, rd_ptr = 1, and a pending load_req is acked.
REQ-043 in_valid toggling every other cycle during a length-3 load: exactly 3 writes occur, with no address skips or duplicates.
REQ-044 Load completion and cmp_release in the same cycle: both banks update correctly (one FULL, one EMPTY) and both pointers toggle.
REQ-045 Reset asserted after 2 of 4 beats:
- all outputs read 0 and bank_full = 2'b00;
- after reset is released, the next load starts at wr_addr 0x0000.

Source files
------------

// File: rtl/weight_bank_scheduler.sv
// Double-buffered weight bank scheduler: the loader fills one bank while compute
// reads the other; each bank cycles EMPTY -> FULL -> IN_USE -> EMPTY.
module weight_bank_scheduler #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              load_is_cnn,
  output logic              load_ack,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en_fc,
  output logic              wr_en_cnn,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              load_done,
  input  logic              cmp_req,
  output logic              cmp_grant,
  output logic              cmp_bank,
  output logic              cmp_active,
  input  logic              cmp_release,
  output logic [1:0]        bank_full
);

  localparam int OFF_W = ADDR_W - 1;
  localparam int CW    = ((LEN_W > OFF_W) ? LEN_W : OFF_W) + 1;

  typedef enum logic { IDLE, LOAD } state_e;
  typedef enum logic [1:0] { EMPTY = 2'd0, FULL = 2'd1, IN_USE = 2'd2 } bank_e;

  state_e             state_q;
  bank_e              bank_q [2];
  logic               fill_ptr_q;
  logic               rd_ptr_q;
  logic               cmp_bank_q;
  logic               cmp_active_q;
  logic               load_ack_q;
  logic               load_done_q;
  logic               cmp_grant_q;
  logic [LEN_W-1:0]   len_q;
  logic               mode_q;
  logic [OFF_W-1:0]   off_q;

  logic beat, last, zero_len, accept, finish, release_ok, grant;

  always_comb begin
    zero_len   = (len_q == '0);
    in_ready   = (state_q == LOAD) && !zero_len;
    beat       = in_valid && in_ready;
    // Widened compare so len-1 never wraps against the offset width
    last       = (CW'(off_q) == (CW'(len_q) - CW'(1)));
    accept     = (state_q == IDLE) && load_req && (bank_q[fill_ptr_q] == EMPTY);
    finish     = (state_q == LOAD) && (zero_len || (beat && last));
    release_ok = cmp_release && cmp_active_q;
    grant      = cmp_req && !cmp_active_q && (bank_q[rd_ptr_q] == FULL);

    wr_en_cnn  = beat && mode_q;
    wr_en_fc   = beat && !mode_q;
    wr_addr    = {fill_ptr_q, off_q};
    load_ack   = load_ack_q;
    load_done  = load_done_q;
    cmp_grant  = cmp_grant_q;
    cmp_bank   = cmp_bank_q;
    cmp_active = cmp_active_q;
    bank_full  = {bank_q[1] == FULL, bank_q[0] == FULL};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bank_q[0]    <= EMPTY;
      bank_q[1]    <= EMPTY;
      fill_ptr_q   <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cmp_bank_q   <= 1'b0;
      cmp_active_q <= 1'b0;
      load_ack_q   <= 1'b0;
      load_done_q  <= 1'b0;
      cmp_grant_q  <= 1'b0;
      len_q        <= '0;
      mode_q       <= 1'b0;
      off_q        <= '0;
    end else begin
      load_ack_q  <= accept;
      load_done_q <= finish;
      cmp_grant_q <= grant;

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LOAD;
            len_q   <= load_len;
            mode_q  <= load_is_cnn;
            off_q   <= '0;
          end
        end
        LOAD: begin
          if (beat) off_q <= off_q + OFF_W'(1);
          if (finish) begin
            state_q            <= IDLE;
            bank_q[fill_ptr_q] <= FULL;
            fill_ptr_q         <= ~fill_ptr_q;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Grant needs cmp_active low and release needs it high, so they never collide;
      // a completing load always targets the bank compute does not own.
      if (release_ok) begin
        bank_q[cmp_bank_q] <= EMPTY;
        rd_ptr_q           <= ~rd_ptr_q;
        cmp_active_q       <= 1'b0;
      end
      if (grant) begin
        bank_q[rd_ptr_q] <= IN_USE;
        cmp_bank_q       <= rd_ptr_q;
        cmp_active_q     <= 1'b1;
      end
    end
  end

endmodule
